// File: rtl/player_mover.sv
// -----------------------------------------------------------------------------
// player_mover
//   Moves a player sprite through a walled grid maze, one STEP-pixel step per
//   advance pulse. A step sequence starts only from a cell-aligned position:
//   the direction and the current cell are latched, the target wall is checked
//   for one cycle, and then the sprite walks until it is aligned in the
//   neighbouring cell.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   button_1/2        raw direction buttons (synchronized internally);
//                     {button_1, button_2}: 0 right, 1 down, 2 left, 3 up
//   advance           one-cycle step request from the top-level sequencer
//   restart           synchronous return to the origin (beats advance)
//   h_walls           horizontal walls, (GRID_H+1) rows x GRID_W columns,
//                     row 0 / column 0 at the MSB; wall sits above cell row r
//   v_walls           vertical walls, GRID_H rows x (GRID_W+1) columns,
//                     row 0 / column 0 at the MSB; wall sits left of column c
//   pos_x, pos_y      pixel position, [8:5] cell, [4:0] sub-cell offset
//   ready             advance will be accepted this cycle
//   moved             one-cycle pulse on every position change
//   blocked           one-cycle pulse when a requested step is refused
//   at_exit           player aligned in the bottom-right cell
// -----------------------------------------------------------------------------
module player_mover #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 15,
  parameter int STEP   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             button_1,
  input  logic                             button_2,
  input  logic                             advance,
  input  logic                             restart,
  input  logic [(GRID_H+1)*GRID_W-1:0]     h_walls,
  input  logic [GRID_H*(GRID_W+1)-1:0]     v_walls,
  output logic [8:0]                       pos_x,
  output logic [8:0]                       pos_y,
  output logic                             ready,
  output logic                             moved,
  output logic                             blocked,
  output logic                             at_exit
);

  localparam int HW_BITS = (GRID_H + 1) * GRID_W;
  localparam int VW_BITS = GRID_H * (GRID_W + 1);
  localparam int HW_AW   = $clog2(HW_BITS);
  localparam int VW_AW   = $clog2(VW_BITS);

  localparam logic [3:0] GX_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] GY_MAX = 4'(GRID_H - 1);
  localparam logic [8:0] EXIT_X = {GX_MAX, 5'd0};
  localparam logic [8:0] EXIT_Y = {GY_MAX, 5'd0};
  localparam logic [8:0] STEP9  = 9'(STEP);

  localparam logic [1:0] ALIGNED = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] MOVING  = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  logic       b1_meta, b1_s, b2_meta, b2_s;
  logic [1:0] state, state_nx;
  logic [1:0] dir, dir_nx;
  logic [3:0] gx, gx_nx, gy, gy_nx;
  logic [8:0] x_nx, y_nx;
  logic       moved_nx, blocked_nx, at_exit_nx;
  logic       take_step;

  function automatic logic h_wall(input logic [HW_BITS-1:0] hw,
                                  input int r, input int c);
    logic [HW_AW-1:0] idx;
    idx = HW_AW'(HW_BITS - 1 - (r * GRID_W + c));
    return hw[idx];
  endfunction

  function automatic logic v_wall(input logic [VW_BITS-1:0] vw,
                                  input int r, input int c);
    logic [VW_AW-1:0] idx;
    idx = VW_AW'(VW_BITS - 1 - (r * (GRID_W + 1) + c));
    return vw[idx];
  endfunction

  // Border test first, so the wall lookup is only meaningful inside the grid.
  function automatic logic path_open(input logic [1:0] d,
                                     input logic [3:0] cx,
                                     input logic [3:0] cy,
                                     input logic [HW_BITS-1:0] hw,
                                     input logic [VW_BITS-1:0] vw);
    logic ok;
    case (d)
      DIR_RIGHT: ok = (cx < GX_MAX) && !v_wall(vw, int'(cy), int'(cx) + 1);
      DIR_DOWN:  ok = (cy < GY_MAX) && !h_wall(hw, int'(cy) + 1, int'(cx));
      DIR_LEFT:  ok = (cx > 4'd0)   && !v_wall(vw, int'(cy), int'(cx));
      default:   ok = (cy > 4'd0)   && !h_wall(hw, int'(cy), int'(cx));
    endcase
    return ok;
  endfunction

  // Plain 9-bit add/subtract: the wall check already proved the target cell
  // exists, so the result never leaves the grid.
  function automatic logic [17:0] step_pos(input logic [1:0] d,
                                           input logic [8:0] x,
                                           input logic [8:0] y);
    logic [8:0] xo, yo;
    xo = x;
    yo = y;
    case (d)
      DIR_RIGHT: xo = x + STEP9;
      DIR_DOWN:  yo = y + STEP9;
      DIR_LEFT:  xo = x - STEP9;
      default:   yo = y - STEP9;
    endcase
    return {xo, yo};
  endfunction

  assign ready = (state != CHECK);

  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    gx_nx      = gx;
    gy_nx      = gy;
    x_nx       = pos_x;
    y_nx       = pos_y;
    moved_nx   = 1'b0;
    blocked_nx = 1'b0;
    take_step  = 1'b0;

    if (restart) begin
      state_nx = ALIGNED;
      x_nx     = 9'd0;
      y_nx     = 9'd0;
    end else begin
      case (state)
        ALIGNED: begin
          if (advance) begin
            dir_nx   = {b1_s, b2_s};
            gx_nx    = pos_x[8:5];
            gy_nx    = pos_y[8:5];
            state_nx = CHECK;
          end
        end
        CHECK: begin
          // Walls are only looked at here; advance is ignored in this state.
          if (path_open(dir, gx, gy, h_walls, v_walls)) begin
            take_step = 1'b1;
          end else begin
            blocked_nx = 1'b1;
            state_nx   = ALIGNED;
          end
        end
        MOVING: begin
          if (advance) take_step = 1'b1;
        end
        default: state_nx = ALIGNED;
      endcase

      if (take_step) begin
        {x_nx, y_nx} = step_pos(dir, pos_x, pos_y);
        moved_nx     = 1'b1;
        // With STEP == 32 the first step already lands aligned.
        state_nx     = (x_nx[4:0] == 5'd0 && y_nx[4:0] == 5'd0) ? ALIGNED : MOVING;
      end
    end

    at_exit_nx = (x_nx == EXIT_X) && (y_nx == EXIT_Y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_meta <= 1'b0;
      b1_s    <= 1'b0;
      b2_meta <= 1'b0;
      b2_s    <= 1'b0;
      state   <= ALIGNED;
      dir     <= DIR_RIGHT;
      gx      <= 4'd0;
      gy      <= 4'd0;
      pos_x   <= 9'd0;
      pos_y   <= 9'd0;
      moved   <= 1'b0;
      blocked <= 1'b0;
      at_exit <= 1'b0;
    end else begin
      b1_meta <= button_1;
      b1_s    <= b1_meta;
      b2_meta <= button_2;
      b2_s    <= b2_meta;
      state   <= state_nx;
      dir     <= dir_nx;
      gx      <= gx_nx;
      gy      <= gy_nx;
      pos_x   <= x_nx;
      pos_y   <= y_nx;
      moved   <= moved_nx;
      blocked <= blocked_nx;
      at_exit <= at_exit_nx;
    end
  end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter GRID_W, default 10, maze width in cells.
REQ-002 Parameter GRID_H, default 15, maze height in cells.
REQ-003 Parameter STEP, default 1, pixels advanced per advance pulse; SHALL be a power of two from 1 to 32.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 button_1, button_2  in  1 each  raw direction buttons, asynchronous to clk.
REQ-007 advance  in  1  one-cycle pulse from the top-level sequencer after the player sprite redraw completes.
REQ-008 restart  in  1  synchronous return-to-origin request.
REQ-009 h_walls  in  (GRID_H+1)*GRID_W  horizontal walls. Row r (0 = top) and column c map to bit 159-(r*10+c) at default size; the wall sits above cell row r.
REQ-010 v_walls  in  GRID_H*(GRID_W+1)  vertical walls. Row r and column c map to bit 164-(r*11+c); the wall sits left of cell column c.
REQ-011 pos_x, pos_y  out  9 each  player pixel offset. Bits [8:5] are the grid cell; bits [4:0] are the sub-cell offset (32-pixel cells).
REQ-012 ready  out  1  high when advance will be accepted.
REQ-013 moved  out  1  one-cycle pulse on every position change.
REQ-014 blocked  out  1  one-cycle pulse when a requested step hits a wall or the border.
REQ-015 at_exit  out  1  high while aligned in cell (GRID_W-1, GRID_H-1).

Function
REQ-016 The buttons SHALL pass through a two-flop synchronizer; direction = {button_1_s, button_2_s}: 0 right, 1 down, 2 left, 3 up.
REQ-017 FSM states SHALL be ALIGNED, CHECK and MOVING.
REQ-018 Aligned means pos_x[4:0]==0 and pos_y[4:0]==0.
REQ-019 ALIGNED + advance: latch the synchronized direction, latch gx=pos_x[8:5] and gy=pos_y[8:5], then go to CHECK.
REQ-020 CHECK SHALL last exactly one cycle with ready low; any advance during CHECK is dropped.
REQ-021 CHECK SHALL evaluate open/closed against the latched direction:
- right: gx<GRID_W-1 and v_walls(gy,gx+1)==0
- down: gy<GRID_H-1 and h_walls(gy+1,gx)==0
- left: gx>0 and v_walls(gy,gx)==0
- up: gy>0 and h_walls(gy,gx)==0
REQ-022 CHECK open: step the position by STEP in the latched direction, pulse moved, and go to MOVING; pos changes 2 cycles after the advance pulse.
REQ-023 CHECK closed: pulse blocked, leave pos unchanged, and return to ALIGNED.
REQ-024 MOVING + advance: step by STEP in the latched direction the next cycle and pulse moved; buttons are ignored.
REQ-025 MOVING SHALL return to ALIGNED on the cycle the step makes the sub-cell offset 0.
REQ-026 Position arithmetic SHALL be 9-bit with no wrap; wall checks guarantee the value stays in range.
REQ-027 restart SHALL have priority over advance in any state: pos=0, state ALIGNED, no moved or blocked pulse, applied next cycle.
REQ-028 ready SHALL be high in ALIGNED and MOVING and low in CHECK.
REQ-029 at_exit SHALL be registered, derived from the updated pos, and valid the same cycle pos updates.
REQ-030 Wall inputs SHALL be sampled only in CHECK; changes at other times have no effect.

Reset
REQ-031 While rst is high: pos_x=0, pos_y=0, state ALIGNED, latched direction 0, synchronizer flops 0, moved=0, blocked=0, at_exit=0.
REQ-032 Leaving reset SHALL give ready=1 on the first clk edge after rst deasserts.
REQ-033 Reset asserted mid-MOVING SHALL discard the partial step immediately, without waiting for a clock edge.

Verification
REQ-034 All walls 0, buttons=00, advance every 4 cycles -> pos_x 0→1 two cycles after the first pulse, then +1 per pulse; 32 pulses give pos_x=32 and the FSM in ALIGNED.
REQ-035 Start (0,0), buttons=10 (left) -> blocked pulse, pos stays 0; buttons=11 (up) -> blocked as well.
REQ-036 v_walls bit 163 set (wall right of cell 0,0), buttons=00 -> blocked; clear the bit and pulse advance -> moved, pos_x=1.
REQ-037 Mid-move (pos_x=5), flip buttons to 01 -> motion stays right until pos_x=32, and the next advance moves down.
REQ-038 Drive the player to cell (9,14) aligned -> at_exit=1; restart together with advance -> pos=0, at_exit=0, no moved pulse.
REQ-039 Assert rst asynchronously mid-MOVING -> outputs go to reset values before the next clk edge.
